seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider_pkg.sv | 14 +
 rtl/seq_divider_sub.sv | 20 ++
 rtl/seq_divider.sv | 97 +++++++++
 tb/tb_seq_divider.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encodings and
// the bit positions of the subtractor's status flags.
package seq_divider_pkg;

   localparam int ZF_BIT = 0;
   localparam int SF_BIT = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_divider_sub.sv
// Combinational subtractor: d = a - b (modulo 2^W) with zero and sign flags.
module seq_divider_sub
   import seq_divider_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] d,
   output logic [1:0]   flags
);

   always_comb begin
      d             = a - b;
      flags         = '0;
      flags[ZF_BIT] = (d == '0);
      flags[SF_BIT] = d[W-1];
   end

endmodule

// File: rtl/seq_divider.sv
// Sequential divider by repeated subtraction: one subtract per clock while
// the partial remainder is not below the divisor.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             zf,
   output logic             err
);

   state_t           state;
   logic [WIDTH-1:0] r_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] sub_d;
   logic [1:0]       sub_flags;
   logic             r_ge_b;
   logic             sign_unused;

   seq_divider_sub #(.W(WIDTH)) u_sub (
      .a     (r_reg),
      .b     (b_reg),
      .d     (sub_d),
      .flags (sub_flags)
   );

   // The subtractor's SF is the MSB of the difference, not an unsigned
   // borrow, so the continue/stop decision uses a local compare instead.
   assign r_ge_b      = (r_reg >= b_reg);
   assign sign_unused = sub_flags[SF_BIT];
   assign R           = r_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         Q     <= '0;
         r_reg <= '0;
         b_reg <= '0;
         zf    <= 1'b1;
         err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  r_reg <= A;
                  zf    <= (A == '0);
                  if (B != '0) begin
                     b_reg <= B;
                     Q     <= '0;
                     err   <= 1'b0;
                     busy  <= 1'b1;
                     state <= RUN;
                  end else begin
                     Q     <= '1;
                     err   <= 1'b1;
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            RUN: begin
               if (r_ge_b) begin
                  r_reg <= sub_d;
                  zf    <= sub_flags[ZF_BIT];
                  Q     <= Q + WIDTH'(1);
               end else begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed operations push expected
// results; a monitor pops and checks them on every done pulse.
module tb_seq_divider;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] A;
   logic [3:0] B;
   logic       busy;
   logic       done;
   logic [3:0] Q;
   logic [3:0] R;
   logic       zf;
   logic       err;

   typedef struct {
      int q;
      int r;
      int zf;
      int err;
      int lat;
      int busy_cycles;
      int done_cyc;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   busy_cnt = 0;

   seq_divider #(.WIDTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .Q     (Q),
      .R     (R),
      .zf    (zf),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: checks every done pulse against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         busy_cnt = 0;
      end else if (done) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
         end else begin
            e = sb.pop_front();
            chk("Q", int'(Q), e.q);
            chk("R", int'(R), e.r);
            chk("zf", int'(zf), e.zf);
            chk("err", int'(err), e.err);
            chk("latency", cyc, e.done_cyc);
            chk("busy_cycles", busy_cnt, e.busy_cycles);
         end
         busy_cnt = 0;
      end else if (busy) begin
         busy_cnt++;
      end
   end

   // Drives one start cycle; returns at the negedge after the sampling edge.
   task automatic issue(input int a, input int b, input bit push,
                        input int q, input int r, input int z, input int e,
                        input int lat, input int bc);
      exp_t x;
      @(negedge clk);
      start = 1'b1;
      A     = 4'(a);
      B     = 4'(b);
      if (push) begin
         x.q = q; x.r = r; x.zf = z; x.err = e;
         x.lat = lat; x.busy_cycles = bc; x.done_cyc = cyc + lat;
         sb.push_back(x);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL timeout_no_done actual=%0d required=0 pending", sb.size());
         sb.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_Q"}, int'(Q), 0);
      chk({tag, "_R"}, int'(R), 0);
      chk({tag, "_zf"}, int'(zf), 1);
      chk({tag, "_err"}, int'(err), 0);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      A     = '0;
      B     = '0;
      repeat (2) @(negedge clk);
      chk_reset_vals("reset");
      rst_n = 1'b1;
      @(negedge clk);

      //    A   B  push Q   R  zf err lat busy
      issue(13, 4, 1,   3,  1, 0, 0,  5,  4);   drain();
      issue(15, 1, 1,   15, 0, 1, 0,  17, 16);  drain();
      issue(3,  7, 1,   0,  3, 0, 0,  2,  1);   drain();
      issue(9,  0, 1,   15, 9, 0, 1,  1,  0);   drain();
      issue(0,  5, 1,   0,  0, 1, 0,  2,  1);   drain();

      // Abort 12/3 with a reset pulse on the second RUN cycle.
      issue(12, 3, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("abort");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      issue(12, 3, 1,   4,  0, 1, 0,  6,  5);   drain();

      // A second start during RUN must be ignored.
      issue(14, 5, 1,   2,  4, 0, 0,  4,  3);
      start = 1'b1;
      A     = 4'd1;
      B     = 4'd1;
      @(negedge clk);
      start = 1'b0;
      drain();

      // A start presented during the DONE cycle is lost.
      issue(5,  0, 1,   15, 5, 0, 1,  1,  0);
      start = 1'b1;
      A     = 4'd6;
      B     = 4'd2;
      @(negedge clk);
      start = 1'b0;
      drain();
      repeat (10) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
